mem_ctrl: RTL

- Single-port arbiter/sequencer for the byte-wide external RAM/IO bus.
- Shares the bus between two requesters:
  - IFetch: 64-byte ICACHE line fill.
  - LSB: 1/2/4-byte loads and stores.
- Serialises every multi-byte access into one byte per cycle, assembles read data little-endian and returns it with a one-cycle done pulse.
- Sits between the core's fetch/load-store units and the RAM/IO bus.

---
 rtl/mem_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial arbiter/sequencer for the shared external RAM/IO bus
module mem_ctrl #(
  parameter int          LINE_BYTES = 64,
  parameter logic [1:0]  IO_SEL     = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_en,
  input  logic [31:0]             if_pc,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [2:0]              lsb_len,
  input  logic [31:0]             lsb_w_data,
  output logic                    lsb_done,
  output logic [31:0]             lsb_r_data
);
  localparam int CW = $clog2(LINE_BYTES + 1);
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, len_q, len_d, nxt;
  logic [31:0]             mem_a_q, mem_a_d, base_q, base_d, wdata_q, wdata_d, lsb_r_data_q, lsb_r_data_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    mem_wr_q, mem_wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [LINE_BYTES*8-1:0] if_data_q, if_data_d;
  logic                    io_stall;
  assign mem_dout   = mem_dout_q;
  assign mem_a      = mem_a_q;
  assign mem_wr     = mem_wr_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign lsb_done   = lsb_done_q;
  assign lsb_r_data = lsb_r_data_q;
  // Next-state: arbitration in IDLE, byte-per-cycle read capture, and store issue with IO back-pressure
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    nxt          = cnt_q + CW'(mem_wr_q);
    io_stall     = 1'b0;
    case (state_q)
      IDLE: if (!(if_done_q || lsb_done_q)) begin
        if (lsb_en && (lsb_wr || !rollback)) begin
          io_stall     = lsb_addr[17:16] == IO_SEL && io_buffer_full;
          state_d      = lsb_wr ? STORE : LOAD;
          cnt_d        = '0;
          len_d        = CW'(lsb_len);
          base_d       = lsb_addr;
          wdata_d      = lsb_w_data;
          mem_a_d      = lsb_addr;
          lsb_r_data_d = lsb_wr ? lsb_r_data_q : '0;
          mem_wr_d     = lsb_wr && !io_stall;
          mem_dout_d   = lsb_wr ? lsb_w_data[7:0] : mem_dout_q;
        end else if (if_en && !lsb_en && !rollback) begin
          state_d = IFETCH;
          cnt_d   = '0;
          len_d   = CW'(LINE_BYTES);
          base_d  = if_pc;
          mem_a_d = if_pc;
        end
      end
      IFETCH, LOAD: begin
        if (rollback) begin
          state_d = IDLE;
          mem_a_d = '0;
        end else begin
          if (state_q == IFETCH) if_data_d[{cnt_q, 3'b000} +: 8] = mem_din;
          else lsb_r_data_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == len_q) begin
            state_d    = IDLE;
            mem_a_d    = '0;
            if_done_d  = state_q == IFETCH;
            lsb_done_d = state_q == LOAD;
          end else begin
            mem_a_d = mem_a_q + 32'd1;
          end
        end
      end
      STORE: begin
        cnt_d = nxt;
        if (nxt == len_q) begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end else begin
          io_stall   = base_q[17:16] == IO_SEL && io_buffer_full;
          mem_a_d    = base_q + 32'(nxt);
          mem_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          mem_wr_d   = !io_stall;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; everything freezes while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
    end
  end
endmodule
